// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI-mode block reader.
//   - command, token and response constants
//   - one-hot FSM state encoding for sd_read_blk
//   - CRC16-CCITT polynomial used by sd_crc16
//   - cmd17_frame(): builds the 48-bit CMD17 frame for a sector address
package sd_pkg;

  localparam logic [7:0]  CMD17       = 8'h51;
  localparam logic [7:0]  TOKEN_START = 8'hFE;
  localparam logic [7:0]  R1_OK       = 8'h00;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  typedef enum logic [6:0] {
    StIdle      = 7'b000_0001,
    StSendCmd   = 7'b000_0010,
    StWaitR1    = 7'b000_0100,
    StWaitToken = 7'b000_1000,
    StRdData    = 7'b001_0000,
    StRdCrc     = 7'b010_0000,
    StTail      = 7'b100_0000
  } sd_rd_state_e;

  // Dummy CRC byte 8'hFF with stop bit: SPI mode ignores CRC for CMD17.
  function automatic logic [47:0] cmd17_frame(input logic [31:0] addr);
    return {CMD17, addr, 8'hFF};
  endfunction

endpackage

// File: rtl/sd_read_blk_if.sv
// Request/response and SPI pin bundle for sd_read_blk.
//   master : the block reader (drives cs/mosi and the rd_* results)
//   slave  : the environment (init stage, requester, card)
// Signals: sd_init_done, rd_start, rd_sec_addr, sd_miso (to reader);
//          sd_cs, sd_mosi, rd_busy, rd_val, rd_data, rd_done, rd_err (from reader).
interface sd_read_blk_if;
  logic        sd_init_done;
  logic        rd_start;
  logic [31:0] rd_sec_addr;
  logic        sd_miso;
  logic        sd_cs;
  logic        sd_mosi;
  logic        rd_busy;
  logic        rd_val;
  logic [7:0]  rd_data;
  logic        rd_done;
  logic        rd_err;

  modport master (
    input  sd_init_done, rd_start, rd_sec_addr, sd_miso,
    output sd_cs, sd_mosi, rd_busy, rd_val, rd_data, rd_done, rd_err
  );

  modport slave (
    output sd_init_done, rd_start, rd_sec_addr, sd_miso,
    input  sd_cs, sd_mosi, rd_busy, rd_val, rd_data, rd_done, rd_err
  );
endinterface

// File: rtl/sd_crc16.sv
// Serial bit-in CRC16-CCITT (poly 0x1021, init 0), MSB-first data.
// Only instantiated by sd_read_blk when SD_RD_CRC16_EN is defined.
// Ports: div_clk, rst_n (async, active-low), i_clr (sync clear, has priority),
//        i_en (consume i_bit this cycle), i_bit, o_crc (current remainder).
module sd_crc16
  import sd_pkg::*;
(
  input  logic        div_clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc_q;
  logic [15:0] w_crc_d;
  logic        w_fb;

  always_comb begin
    w_fb    = i_bit ^ r_crc_q[15];
    w_crc_d = r_crc_q;
    if (i_clr) begin
      w_crc_d = '0;
    end else if (i_en) begin
      w_crc_d = {r_crc_q[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) r_crc_q <= '0;
    else        r_crc_q <= w_crc_d;
  end

  assign o_crc = r_crc_q;

endmodule

// File: rtl/sd_read_blk.sv
// SPI-mode single-block (CMD17) reader for SD cards.
// Issues CMD17, waits for R1 and the start token, streams BLK_BYTES bytes out on
// rd_val/rd_data, clocks past the CRC16, then holds cs high for TAIL_CLKS clocks
// and pulses rd_done with rd_err.
// Ports: div_clk (sd_clk = ~div_clk outside), rst_n (async, active-low),
//        bus (sd_read_blk_if.master: request, result and SPI pins).
// Build option: define SD_RD_CRC16_EN to check the data CRC16 and flag a
// mismatch on rd_err; otherwise the CRC bits are discarded.
module sd_read_blk
  import sd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_NUM = 16'd50000,
  parameter logic [9:0]  BLK_BYTES   = 10'd512,
  parameter logic [3:0]  TAIL_CLKS   = 4'd8
) (
  input logic           div_clk,
  input logic           rst_n,
  sd_read_blk_if.master bus
);

  sd_rd_state_e r_state_q, w_state_d;
  logic [31:0]  r_addr_q, w_addr_d;
  logic [5:0]   r_bit_cnt_q, w_bit_cnt_d;
  logic [9:0]   r_byte_cnt_q, w_byte_cnt_d;
  logic [15:0]  r_to_cnt_q, w_to_cnt_d;
  logic [3:0]   r_tail_cnt_q, w_tail_cnt_d;
  logic [7:0]   r_shift_q, w_shift_d;
  logic         r_cap_q, w_cap_d;
  logic         r_cs_q, w_cs_d;
  logic         r_mosi_q, w_mosi_d;
  logic         r_busy_q, w_busy_d;
  logic         r_val_q, w_val_d;
  logic [7:0]   r_data_q, w_data_d;
  logic         r_done_q, w_done_d;
  logic         r_err_q, w_err_d;
  logic         r_miso_q;

  logic [47:0]  w_frame;
  logic [7:0]   w_byte;
  logic         w_to_hit;
  logic         w_crc_ok;

  // Card output is sampled on the sd_clk rising edge, half a cycle before use.
  always_ff @(negedge div_clk or negedge rst_n) begin
    if (!rst_n) r_miso_q <= 1'b1;
    else        r_miso_q <= bus.sd_miso;
  end

`ifdef SD_RD_CRC16_EN
  logic [15:0] w_crc;
  logic [14:0] r_crc_rx_q;

  sd_crc16 u_crc16 (
    .div_clk (div_clk),
    .rst_n   (rst_n),
    .i_clr   (r_state_q == StWaitToken),
    .i_en    (r_state_q == StRdData),
    .i_bit   (r_miso_q),
    .o_crc   (w_crc)
  );

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n)                      r_crc_rx_q <= '0;
    else if (r_state_q == StRdCrc) r_crc_rx_q <= {r_crc_rx_q[13:0], r_miso_q};
  end

  // Evaluated on the 16th CRC bit, which is still in r_miso_q.
  assign w_crc_ok = ({r_crc_rx_q, r_miso_q} == w_crc);
`else
  assign w_crc_ok = 1'b1;
`endif

  assign w_frame  = cmd17_frame(r_addr_q);
  assign w_byte   = {r_shift_q[6:0], r_miso_q};
  assign w_to_hit = (r_to_cnt_q == TIMEOUT_NUM - 16'd1);

  always_comb begin
    w_state_d    = r_state_q;
    w_addr_d     = r_addr_q;
    w_bit_cnt_d  = r_bit_cnt_q;
    w_byte_cnt_d = r_byte_cnt_q;
    w_to_cnt_d   = r_to_cnt_q;
    w_tail_cnt_d = r_tail_cnt_q;
    w_shift_d    = r_shift_q;
    w_cap_d      = r_cap_q;
    w_cs_d       = 1'b1;
    w_mosi_d     = 1'b1;
    w_busy_d     = r_busy_q;
    w_val_d      = 1'b0;
    w_data_d     = r_data_q;
    w_done_d     = 1'b0;
    w_err_d      = r_err_q;

    unique case (r_state_q)
      StIdle: begin
        // r_done_q blocks a request landing in the rd_done cycle.
        if (bus.rd_start && bus.sd_init_done && !r_busy_q && !r_done_q) begin
          w_addr_d    = bus.rd_sec_addr;
          w_err_d     = 1'b0;
          w_busy_d    = 1'b1;
          w_bit_cnt_d = '0;
          w_state_d   = StSendCmd;
        end
      end
      StSendCmd: begin
        w_cs_d   = 1'b0;
        w_mosi_d = w_frame[6'd47 - r_bit_cnt_q];
        if (r_bit_cnt_q == 6'd47) begin
          w_bit_cnt_d = '0;
          w_to_cnt_d  = '0;
          w_cap_d     = 1'b0;
          w_state_d   = StWaitR1;
        end else begin
          w_bit_cnt_d = r_bit_cnt_q + 6'd1;
        end
      end
      StWaitR1: begin
        w_cs_d     = 1'b0;
        w_to_cnt_d = r_to_cnt_q + 16'd1;
        // The first 0 bit is R1 bit 7; capture from there.
        if (r_cap_q || !r_miso_q) begin
          w_cap_d     = 1'b1;
          w_shift_d   = w_byte;
          w_bit_cnt_d = r_bit_cnt_q + 6'd1;
        end
        if (r_cap_q && (r_bit_cnt_q == 6'd7)) begin
          w_bit_cnt_d = '0;
          if (w_byte == R1_OK) begin
            w_to_cnt_d = '0;
            w_shift_d  = 8'hFF;
            w_state_d  = StWaitToken;
          end else begin
            w_err_d      = 1'b1;
            w_tail_cnt_d = '0;
            w_state_d    = StTail;
          end
        end else if (w_to_hit) begin
          w_err_d      = 1'b1;
          w_tail_cnt_d = '0;
          w_state_d    = StTail;
        end
      end
      StWaitToken: begin
        w_cs_d     = 1'b0;
        w_to_cnt_d = r_to_cnt_q + 16'd1;
        w_shift_d  = w_byte;
        // The token's only 0 bit is its last, so the first 0 closes the byte.
        if (!r_miso_q) begin
          if (w_byte == TOKEN_START) begin
            w_to_cnt_d   = '0;
            w_bit_cnt_d  = '0;
            w_byte_cnt_d = '0;
            w_state_d    = StRdData;
          end else begin
            w_err_d      = 1'b1;
            w_tail_cnt_d = '0;
            w_state_d    = StTail;
          end
        end else if (w_to_hit) begin
          w_err_d      = 1'b1;
          w_tail_cnt_d = '0;
          w_state_d    = StTail;
        end
      end
      StRdData: begin
        w_cs_d    = 1'b0;
        w_shift_d = w_byte;
        if (r_bit_cnt_q == 6'd7) begin
          w_bit_cnt_d = '0;
          w_data_d    = w_byte;
          w_val_d     = 1'b1;
          if (r_byte_cnt_q == BLK_BYTES - 10'd1) begin
            w_state_d = StRdCrc;
          end else begin
            w_byte_cnt_d = r_byte_cnt_q + 10'd1;
          end
        end else begin
          w_bit_cnt_d = r_bit_cnt_q + 6'd1;
        end
      end
      StRdCrc: begin
        w_cs_d = 1'b0;
        if (r_bit_cnt_q == 6'd15) begin
          if (!w_crc_ok) w_err_d = 1'b1;
          w_bit_cnt_d  = '0;
          w_tail_cnt_d = '0;
          w_cs_d       = 1'b1;
          w_state_d    = StTail;
        end else begin
          w_bit_cnt_d = r_bit_cnt_q + 6'd1;
        end
      end
      StTail: begin
        if (r_tail_cnt_q == TAIL_CLKS - 4'd1) begin
          w_tail_cnt_d = '0;
          w_done_d     = 1'b1;
          w_busy_d     = 1'b0;
          w_state_d    = StIdle;
        end else begin
          w_tail_cnt_d = r_tail_cnt_q + 4'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge div_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q    <= StIdle;
      r_addr_q     <= '0;
      r_bit_cnt_q  <= '0;
      r_byte_cnt_q <= '0;
      r_to_cnt_q   <= '0;
      r_tail_cnt_q <= '0;
      r_shift_q    <= '0;
      r_cap_q      <= 1'b0;
      r_cs_q       <= 1'b1;
      r_mosi_q     <= 1'b1;
      r_busy_q     <= 1'b0;
      r_val_q      <= 1'b0;
      r_data_q     <= '0;
      r_done_q     <= 1'b0;
      r_err_q      <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_addr_q     <= w_addr_d;
      r_bit_cnt_q  <= w_bit_cnt_d;
      r_byte_cnt_q <= w_byte_cnt_d;
      r_to_cnt_q   <= w_to_cnt_d;
      r_tail_cnt_q <= w_tail_cnt_d;
      r_shift_q    <= w_shift_d;
      r_cap_q      <= w_cap_d;
      r_cs_q       <= w_cs_d;
      r_mosi_q     <= w_mosi_d;
      r_busy_q     <= w_busy_d;
      r_val_q      <= w_val_d;
      r_data_q     <= w_data_d;
      r_done_q     <= w_done_d;
      r_err_q      <= w_err_d;
    end
  end

  assign bus.sd_cs   = r_cs_q;
  assign bus.sd_mosi = r_mosi_q;
  assign bus.rd_busy = r_busy_q;
  assign bus.rd_val  = r_val_q;
  assign bus.rd_data = r_data_q;
  assign bus.rd_done = r_done_q;
  assign bus.rd_err  = r_err_q;

endmodule

// File: tb/tb_sd_read_blk.sv
// Directed bench for sd_read_blk with a bit-level SPI card model.
module tb_sd_read_blk;

  logic div_clk;
  logic rst_n;
  sd_read_blk_if bus ();

  sd_read_blk u_dut (
    .div_clk (div_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial begin
    div_clk = 1'b0;
    forever #5 div_clk = ~div_clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge div_clk);
    cyc++;
  end

  // Card model ---------------------------------------------------------------
  logic [7:0]  card_r1 = 8'h00;
  bit          card_silent = 1'b0;
  bit          card_bad_crc = 1'b0;
  bit          resp_q[$];
  int          cmd_bits = 0;
  int          cmd_cnt = 0;
  logic [47:0] cmd_sr = '0;
  logic [47:0] last_cmd = '0;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) resp_q.push_back(v[b]);
  endtask

  // One 0xFF of Ncr, R1, one 0xFF gap, token, data i%256, CRC16.
  task automatic build_resp();
    logic [15:0] crc;
    push_byte(8'hFF);
    push_byte(card_r1);
    if (card_r1 == 8'h00) begin
      push_byte(8'hFF);
      push_byte(8'hFE);
      crc = '0;
      for (int i = 0; i < 512; i++) begin
        push_byte(i[7:0]);
        crc = crc16_byte(crc, i[7:0]);
      end
      if (card_bad_crc) crc[3] = ~crc[3];
      push_byte(crc[15:8]);
      push_byte(crc[7:0]);
    end
  endtask

  initial forever begin
    @(negedge div_clk);
    if (!rst_n || bus.sd_cs) begin
      cmd_bits = 0;
    end else if (cmd_bits < 48) begin
      cmd_sr = {cmd_sr[46:0], bus.sd_mosi};
      cmd_bits++;
      if (cmd_bits == 48) begin
        last_cmd = cmd_sr;
        cmd_cnt++;
        if (!card_silent) build_resp();
      end
    end
  end

  initial begin
    bus.sd_miso = 1'b1;
    forever begin
      @(posedge div_clk);
      #1;
      if (resp_q.size() > 0) bus.sd_miso = resp_q.pop_front();
      else                   bus.sd_miso = 1'b1;
    end
  end

  // Output monitor -----------------------------------------------------------
  logic [7:0] rx_q[$];
  int first_val_cyc = 0;

  initial forever begin
    @(posedge div_clk);
    #1;
    if (bus.rd_val) begin
      if (rx_q.size() == 0) first_val_cyc = cyc;
      rx_q.push_back(bus.rd_data);
    end
  end

  // Helpers ------------------------------------------------------------------
  int   start_cyc;
  int   done_lat;
  logic done_err;

  task automatic check_reset_vals();
    check_eq("rst_cs", bus.sd_cs, 1);
    check_eq("rst_mosi", bus.sd_mosi, 1);
    check_eq("rst_busy", bus.rd_busy, 0);
    check_eq("rst_val", bus.rd_val, 0);
    check_eq("rst_data", bus.rd_data, 0);
    check_eq("rst_done", bus.rd_done, 0);
    check_eq("rst_err", bus.rd_err, 0);
  endtask

  // poke_at: cycle (counted from the accept edge) to pulse a second rd_start.
  // poke_done: pulse rd_start during the rd_done cycle.
  task automatic run_read(input logic [31:0] a, input int limit, input int poke_at,
                          input bit poke_done);
    @(posedge div_clk);
    #1;
    rx_q.delete();
    bus.rd_sec_addr = a;
    bus.rd_start    = 1'b1;
    @(posedge div_clk);
    #1;
    bus.rd_start = 1'b0;
    start_cyc    = cyc;
    done_lat     = 1;
    check_eq("busy_on_accept", bus.rd_busy, 1);
    while (!bus.rd_done && done_lat < limit) begin
      if (done_lat == poke_at) begin
        bus.rd_start    = 1'b1;
        bus.rd_sec_addr = 32'hDEAD_BEEF;
      end
      @(posedge div_clk);
      #1;
      bus.rd_start = 1'b0;
      done_lat++;
    end
    check_eq("done_seen", bus.rd_done, 1);
    check_eq("busy_at_done", bus.rd_busy, 0);
    check_eq("cs_at_done", bus.sd_cs, 1);
    done_err = bus.rd_err;
    if (poke_done) bus.rd_start = 1'b1;
    @(posedge div_clk);
    #1;
    bus.rd_start = 1'b0;
    check_eq("done_one_cycle", bus.rd_done, 0);
    check_eq("busy_after_done", bus.rd_busy, 0);
  endtask

  task automatic check_block();
    check_eq("rx_count", rx_q.size(), 512);
    for (int i = 0; i < rx_q.size() && i < 512; i++) check_eq("rx_byte", rx_q[i], i % 256);
  endtask

  // Stimulus -----------------------------------------------------------------
  logic [7:0] exp_cmd [6] = '{8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'hFF};
  int n;

  initial begin
    rst_n            = 1'b0;
    bus.sd_init_done = 1'b0;
    bus.rd_start     = 1'b0;
    bus.rd_sec_addr  = '0;
    #23;
    check_reset_vals();
    @(negedge div_clk);
    rst_n = 1'b1;
    repeat (3) @(posedge div_clk);

    // Requests before init done are ignored.
    #1;
    bus.rd_start = 1'b1;
    @(posedge div_clk);
    #1;
    bus.rd_start = 1'b0;
    repeat (60) @(posedge div_clk);
    #1;
    check_eq("noinit_busy", bus.rd_busy, 0);
    check_eq("noinit_cs", bus.sd_cs, 1);
    check_eq("noinit_cmds", cmd_cnt, 0);
    bus.sd_init_done = 1'b1;

    // Good read; extra requests mid-read and in the rd_done cycle are ignored.
    run_read(32'h0000_1234, 6000, 300, 1'b1);
    check_eq("ok_err", done_err, 0);
    check_eq("ok_first_val_lat", first_val_cyc - start_cyc + 1, 90);
    check_eq("ok_cmd_cnt", cmd_cnt, 1);
    for (int i = 0; i < 6; i++) check_eq("cmd_byte", last_cmd[47 - 8*i -: 8], exp_cmd[i]);
    check_block();
    repeat (20) @(posedge div_clk);
    #1;
    check_eq("no_second_read", cmd_cnt, 1);
    check_eq("idle_busy", bus.rd_busy, 0);

    // R1 error.
    card_r1 = 8'h05;
    run_read(32'h0000_0007, 2000, -1, 1'b0);
    check_eq("r1_err", done_err, 1);
    check_eq("r1_done_lat", done_lat, 74);
    check_eq("r1_no_val", rx_q.size(), 0);
    card_r1 = 8'h00;

    // Silent card: R1 timeout.
    card_silent = 1'b1;
    run_read(32'h0000_0008, 60000, -1, 1'b0);
    check_eq("to_err", done_err, 1);
    check_eq("to_done_lat", done_lat, 50057);
    check_eq("to_no_val", rx_q.size(), 0);
    card_silent = 1'b0;

    // Reset in the middle of the data phase.
    @(posedge div_clk);
    #1;
    rx_q.delete();
    bus.rd_sec_addr = 32'h0000_0100;
    bus.rd_start    = 1'b1;
    @(posedge div_clk);
    #1;
    bus.rd_start = 1'b0;
    n = 0;
    while (rx_q.size() < 100 && n < 5000) begin
      @(posedge div_clk);
      #2;
      n++;
    end
    check_eq("mid_reached_100", rx_q.size(), 100);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    resp_q.delete();
    repeat (3) @(posedge div_clk);
    #1;
    check_eq("mid_no_more_val", rx_q.size(), 100);
    @(negedge div_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge div_clk);
    run_read(32'h0000_0101, 6000, -1, 1'b0);
    check_eq("after_rst_err", done_err, 0);
    check_block();

    // Corrupted CRC: only flagged when the checker is built in.
    card_bad_crc = 1'b1;
    run_read(32'h0000_0200, 6000, -1, 1'b0);
`ifdef SD_RD_CRC16_EN
    check_eq("badcrc_err", done_err, 1);
`else
    check_eq("badcrc_err", done_err, 0);
`endif
    check_block();
    card_bad_crc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
